// File: rtl/xadc_drp_responder.sv
// XADC-style DRP target: status registers fed by a periodic conversion sequencer,
// a 32-entry control/limit bank, and alarm outputs derived from the limits.
module xadc_drp_responder #(
  parameter int READ_LATENCY = 4,
  parameter int EOC_PERIOD   = 256
) (
  input  logic        dclk,
  input  logic        reset,
  input  logic [6:0]  daddr,
  input  logic        den,
  input  logic        dwe,
  input  logic [15:0] di,
  output logic [15:0] do_data,   // DRP "do" bus; the bare name is a language keyword
  output logic        drdy,
  input  logic [15:0] sensor_temp,
  input  logic [15:0] sensor_vccint,
  input  logic [15:0] sensor_vccaux,
  input  logic [15:0] sensor_vccbram,
  output logic        eoc,
  output logic        eos,
  output logic [3:0]  alarm,
  output logic        drp_error
);

  localparam int CW = (EOC_PERIOD > 1) ? $clog2(EOC_PERIOD) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state;
  logic [3:0]     lat;
  logic [6:0]     addr_q;
  logic           we_q;
  logic [15:0]    wdata_q;
  logic [15:0]    rdata_q;
  logic [15:0]    rd_mux;
  logic [15:0]    status [4];
  logic [15:0]    ctrl   [32];
  logic [CW-1:0]  seq_cnt;
  logic [1:0]     ch;
  logic [1:0]     upd_ch;
  logic [15:0]    sens;

  function automatic logic [15:0] ctrl_rst(input int i);
    case (i)
      16: return 16'hB5ED;
      17: return 16'h57E4;
      18: return 16'hA147;
      20: return 16'h9A3A;
      21: return 16'h52C6;
      22: return 16'h9555;
      24: return 16'h5999;
      28: return 16'h5111;
      default: return 16'h0000;
    endcase
  endfunction

  always_comb begin
    rd_mux = '0;
    case (daddr)
      7'h00: rd_mux = status[0];
      7'h01: rd_mux = status[1];
      7'h02: rd_mux = status[2];
      7'h06: rd_mux = status[3];
      default: if (daddr[6:5] == 2'b10) rd_mux = ctrl[daddr[4:0]];
    endcase
  end

  // Read data is captured at acceptance; writes land on the drdy cycle's edge.
  always_ff @(posedge dclk) begin
    if (reset) begin
      state     <= IDLE;
      lat       <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      drdy      <= 1'b0;
      do_data   <= '0;
      drp_error <= 1'b0;
      for (int i = 0; i < 32; i++) ctrl[i] <= ctrl_rst(i);
    end else begin
      drdy    <= 1'b0;
      do_data <= '0;
      if (den && state == BUSY) drp_error <= 1'b1;
      case (state)
        IDLE: if (den) begin
          addr_q  <= daddr;
          we_q    <= dwe;
          wdata_q <= di;
          rdata_q <= rd_mux;
          lat     <= 4'(READ_LATENCY - 1);
          state   <= BUSY;
          if (READ_LATENCY == 1) begin
            drdy    <= 1'b1;
            do_data <= dwe ? 16'h0000 : rd_mux;
          end
        end
        BUSY: begin
          if (lat == 4'd0) begin
            state <= IDLE;
            if (we_q && addr_q[6:5] == 2'b10) ctrl[addr_q[4:0]] <= wdata_q;
          end else begin
            lat <= lat - 4'd1;
            if (lat == 4'd1) begin
              drdy    <= 1'b1;
              do_data <= we_q ? 16'h0000 : rdata_q;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    case (ch)
      2'd0:    sens = sensor_temp;
      2'd1:    sens = sensor_vccint;
      2'd2:    sens = sensor_vccaux;
      default: sens = sensor_vccbram;
    endcase
  end

  // Alarms look at the channel updated by the previous cycle's eoc.
  always_ff @(posedge dclk) begin
    if (reset) begin
      seq_cnt <= '0;
      ch      <= '0;
      upd_ch  <= '0;
      eoc     <= 1'b0;
      eos     <= 1'b0;
      alarm   <= '0;
      for (int i = 0; i < 4; i++) status[i] <= '0;
    end else begin
      eoc <= 1'b0;
      eos <= 1'b0;
      if (seq_cnt == CW'(EOC_PERIOD - 1)) begin
        seq_cnt    <= '0;
        eoc        <= 1'b1;
        eos        <= (ch == 2'd3);
        upd_ch     <= ch;
        ch         <= ch + 2'd1;
        status[ch] <= sens;
      end else begin
        seq_cnt <= seq_cnt + 1'b1;
      end
      if (eoc) begin
        case (upd_ch)
          2'd0: begin
            if (status[0] > ctrl[16])      alarm[0] <= 1'b1;
            else if (status[0] < ctrl[20]) alarm[0] <= 1'b0;
          end
          2'd1: alarm[1] <= (status[1] > ctrl[17]) || (status[1] < ctrl[21]);
          2'd2: alarm[2] <= (status[2] > ctrl[18]) || (status[2] < ctrl[22]);
          default: alarm[3] <= (status[3] > ctrl[24]) || (status[3] < ctrl[28]);
        endcase
      end
    end
  end

endmodule

// File: doc/xadc_drp_responder.md
# xadc_drp_responder

XADC-compatible DRP target that emulates the on-chip sensor monitor for boards and benches without a usable XADC primitive. It answers DRP reads/writes on the same port signals a DRP initiator drives into the XADC. It periodically captures four externally supplied sensor words into status registers, pulsing `eoc`/`eos`. It keeps a writable control/limit register bank and derives alarm outputs from it, so existing sensor-polling logic runs unchanged against it.

## Interface
- `READ_LATENCY`, 4: cycles from accepted `den` to `drdy`; legal 1..15.
- `EOC_PERIOD`, 256: cycles between successive `eoc` pulses; legal ≥ 8.
- `dclk` in 1: sole clock; everything synchronous to its rising edge.
- `reset` in 1: synchronous, active-high.
- `daddr` in 7: DRP register address, sampled with `den`.
- `den` in 1: DRP enable, one-cycle strobe.
- `dwe` in 1: write enable, sampled with `den`.
- `di` in 16: write data, sampled with `den`.
- `do` out 16: read data, valid only while `drdy`=1, else 0.
- `drdy` out 1: one-cycle transaction-complete pulse.
- `sensor_temp`, `sensor_vccint`, `sensor_vccaux`, `sensor_vccbram` in 16 each: raw sensor words.
- `eoc` out 1: end-of-conversion pulse.
- `eos` out 1: end-of-sequence pulse.
- `alarm` out 4: [0] temp, [1] vccint, [2] vccaux, [3] vccbram.
- `drp_error` out 1: sticky; set when `den` arrives while busy.

## Operation
- Register map: 0x00 temp, 0x01 vccint, 0x02 vccaux, 0x06 vccbram status (read-only); 0x40–0x5F control bank (32×16, read/write). Every other address reads 0x0000, and writes to it are discarded.
- Control reset values: 0x50=B5ED, 0x51=57E4, 0x52=A147, 0x54=9A3A, 0x55=52C6, 0x56=9555, 0x58=5999, 0x5C=5111; all others 0x0000. Status registers reset to 0x0000.
- DRP FSM: IDLE → BUSY on `den`. On acceptance it latches `daddr`, `dwe`, `di`, and for reads the addressed register contents. BUSY counts down `READ_LATENCY`. In the final cycle it pulses `drdy`, drives `do` (reads) or commits `di` (writes, `do`=0), then returns to IDLE.
- `den` during BUSY, including the `drdy` cycle, is ignored and sets `drp_error`. The in-flight transaction is unaffected.
- Conversion sequencer: free-running counter 0..`EOC_PERIOD`-1 plus channel index 0→1→2→3→0 (temp, vccint, vccaux, vccbram). At count `EOC_PERIOD`-1:
  - `eoc` pulses.
  - The current channel's status register loads its sensor input sampled that cycle.
  - The index advances.
  - `eos` pulses with `eoc` when the index was 3.
- Alarms are evaluated one cycle after the `eoc` that updated the channel. All comparisons are 16-bit unsigned.
  - temp: set when status > reg 0x50; clear when status < reg 0x54; otherwise hold.
  - vccint: status > 0x51 or < 0x55.
  - vccaux: status > 0x52 or < 0x56.
  - vccbram: status > 0x58 or < 0x5C.
  - Bits [3:1] are recomputed on each update, with no hysteresis.

## Timing
- Reset values: `do`=0, `drdy`=0, `eoc`=0, `eos`=0, `alarm`=0, `drp_error`=0. FSM is IDLE; counter and channel index are 0.
- Read/write latency: `den` at cycle t → `drdy` at t+`READ_LATENCY`. The earliest accepted next `den` is t+`READ_LATENCY`+1.
- Read data is the register value at cycle t (capture at acceptance). A status update at cycle t is not visible; at t+1 it is.
- Write commits at the `drdy` cycle. A limit written there is used by alarm evaluations from the next cycle on; an evaluation in the same cycle uses the old limit.
- First `eoc` occurs `EOC_PERIOD` cycles after `reset` deasserts. The first `eos` occurs at 4×`EOC_PERIOD`.
- `eoc`/`eos` timing is independent of DRP activity.
- Reset mid-transaction aborts it: no `drdy`, no write, registers restored to reset values.

## Test plan
- Read timing: with `READ_LATENCY`=4, `daddr`=0x50 read at t → `drdy`=1 at t+4 only, `do`=B5ED. The `do` line is 0 on every other cycle.
- Write/readback: write 0x41←2EF0, then read 0x41 → 2EF0. Write 0x03←1234, then read 0x03 → 0000; no write occurs to read-only/unmapped space.
- Sequencer: sensors = 1111/2222/3333/4444 → `eoc` at cycles 256, 512, 768, 1024 after reset release. `eos` pulses only at 1024. Reads of 0x00/0x01/0x02/0x06 then return 1111/2222/3333/4444.
- Alarms: sensor_temp=C000 → `alarm[0]`=1 one cycle after the temp `eoc`. Drop it to A000 → `alarm[0]` stays 1. Drop it to 9000 → it clears. sensor_vccint=5000 (< 52C6) → `alarm[1]`=1.
- Protocol errors: `den` at t and again at t+2 → one `drdy` at t+4 with the first transaction's result, and `drp_error`=1 until reset.
- Reset mid-operation: write 0x50←FFFF accepted, then `reset` at t+2 → no `drdy`. A read of 0x50 after release returns B5ED, and all outputs are 0 during reset.
